bt_cmd_ctrl: RTL and testbench

Command-frame controller that sits directly downstream of the Bluetooth UART byte receiver. It sequences received bytes into fixed 4-byte command frames (sync, command, argument, checksum) and enforces an inter-byte timeout. Validated commands go to the application logic over a valid/ack handshake. Rejected frames are counted for debug display.

---
 rtl/bt_cmd_ctrl_pkg.sv | 25 ++
 rtl/bt_cmd_ctrl_if.sv | 24 ++
 rtl/bt_cmd_ctrl_timer.sv | 33 +++
 rtl/bt_cmd_ctrl.sv | 114 +++++++++++
 tb/tb_bt_cmd_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bt_cmd_ctrl_pkg.sv
// Shared Bluetooth command definitions: FSM encoding, sync marker, command codes.
package bt_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      GET_CMD   = 2'd1,
      GET_ARG   = 2'd2,
      GET_CHK   = 2'd3
   } bt_state_e;

   localparam logic [7:0] BT_SYNC_BYTE = 8'hA5;

   localparam logic [7:0] CMD_NOP       = 8'h00;
   localparam logic [7:0] CMD_SET_LED   = 8'h01;
   localparam logic [7:0] CMD_SET_SPEED = 8'h02;
   localparam logic [7:0] CMD_QUERY     = 8'h03;

   // Expected checksum byte for a frame: XOR of sync, command and argument.
   function automatic logic [7:0] bt_frame_chk(input logic [7:0] sync,
                                               input logic [7:0] cmd,
                                               input logic [7:0] arg);
      return sync ^ cmd ^ arg;
   endfunction

endpackage

// File: rtl/bt_cmd_ctrl_if.sv
// Byte-in / command-out bus of the command-frame controller.
interface bt_cmd_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] cmd_out;
   logic [7:0] arg_out;
   logic       cmd_valid;
   logic       cmd_ack;
   logic       err_pulse;
   logic [7:0] err_count;
   logic       busy;

   // Environment side: UART byte source plus command consumer.
   modport master (
      output rx_data, rx_valid, cmd_ack,
      input  cmd_out, arg_out, cmd_valid, err_pulse, err_count, busy
   );

   // Controller side.
   modport slave (
      input  rx_data, rx_valid, cmd_ack,
      output cmd_out, arg_out, cmd_valid, err_pulse, err_count, busy
   );
endinterface

// File: rtl/bt_cmd_ctrl_timer.sv
// Inter-byte timeout counter: expire_o flags the cycle the gap limit is hit.
module bt_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear dominates; count only while a frame is open.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // A byte arriving on the last allowed cycle still counts as in time.
   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Command-frame controller: assembles SYNC/CMD/ARG/CHK frames from UART bytes,
// hands good commands to the application via valid/ack, counts rejected frames.
module bt_cmd_ctrl
   import bt_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = BT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input logic         clk,
   input logic         reset,
   bt_cmd_ctrl_if.slave bus
);

   bt_state_e  state_q, state_d;
   logic [7:0] cmd_lat_q, cmd_lat_d;
   logic [7:0] arg_lat_q, arg_lat_d;
   logic [7:0] cmd_out_q, cmd_out_d;
   logic [7:0] arg_out_q, arg_out_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       expire;

   bt_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (bus.rx_valid || (state_q == WAIT_SYNC)),
      .en_i     (state_q != WAIT_SYNC),
      .expire_o (expire)
   );

   // Next state, frame latches, handshake and error bookkeeping.
   always_comb begin
      state_d     = state_q;
      cmd_lat_d   = cmd_lat_q;
      arg_lat_d   = arg_lat_q;
      cmd_out_d   = cmd_out_q;
      arg_out_d   = arg_out_q;
      // An ack retires the pending command before any new frame is considered.
      cmd_valid_d = cmd_valid_q && !bus.cmd_ack;
      err_d       = 1'b0;
      unique case (state_q)
         WAIT_SYNC: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = GET_CMD;
         GET_CMD: begin
            if (bus.rx_valid) begin
               cmd_lat_d = bus.rx_data;
               state_d   = GET_ARG;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = WAIT_SYNC;
            end
         end
         GET_ARG: begin
            if (bus.rx_valid) begin
               arg_lat_d = bus.rx_data;
               state_d   = GET_CHK;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = WAIT_SYNC;
            end
         end
         GET_CHK: begin
            if (bus.rx_valid) begin
               state_d = WAIT_SYNC;
               if (bus.rx_data != bt_frame_chk(SYNC_BYTE, cmd_lat_q, arg_lat_q)) begin
                  err_d = 1'b1;
               end else if (cmd_valid_d) begin
                  err_d = 1'b1;  // overrun: keep the pending command
               end else begin
                  cmd_out_d   = cmd_lat_q;
                  arg_out_d   = arg_lat_q;
                  cmd_valid_d = 1'b1;
               end
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = WAIT_SYNC;
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_SYNC;
         cmd_lat_q   <= '0;
         arg_lat_q   <= '0;
         cmd_out_q   <= '0;
         arg_out_q   <= '0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmd_lat_q   <= cmd_lat_d;
         arg_lat_q   <= arg_lat_d;
         cmd_out_q   <= cmd_out_d;
         arg_out_q   <= arg_out_d;
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.cmd_out   = cmd_out_q;
   assign bus.arg_out   = arg_out_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.err_pulse = err_q;
   assign bus.err_count = err_cnt_q;
   assign bus.busy      = (state_q != WAIT_SYNC);

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Randomized + directed bench for bt_cmd_ctrl against a frame-buffer reference model.
module tb_bt_cmd_ctrl;

   localparam int T = 16;
   localparam logic [7:0] SY = 8'hA5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bt_cmd_ctrl_if bus();

   bt_cmd_ctrl #(.SYNC_BYTE(SY), .TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: bytes of the open frame, idle gap, pending command.
   logic [7:0] fr[$];
   int         idle;
   bit         m_valid, m_err;
   logic [7:0] m_cmd, m_arg;
   int         m_cnt;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      fr.delete();
      idle = 0; m_valid = 0; m_err = 0; m_cmd = 0; m_arg = 0; m_cnt = 0;
   endtask

   // Outcome of one clock cycle given the inputs present during it.
   task automatic model(input bit rv, input logic [7:0] d, input bit ak);
      bit ld = 0;
      m_err = 0;
      if (fr.size() == 0) begin
         if (rv && d == SY) begin fr.push_back(d); idle = 0; end
      end else if (rv) begin
         fr.push_back(d);
         idle = 0;
         if (fr.size() == 4) begin
            if (fr[3] != (fr[1] ^ fr[2] ^ SY)) m_err = 1;
            else if (m_valid && !ak)           m_err = 1;
            else begin ld = 1; m_cmd = fr[1]; m_arg = fr[2]; end
            fr.delete();
         end
      end else begin
         idle++;
         if (idle == T) begin m_err = 1; fr.delete(); end
      end
      m_valid = (m_valid && !ak) || ld;
      if (m_err && m_cnt < 255) m_cnt++;
   endtask

   task automatic check_all();
      chk("cmd_valid", bus.cmd_valid, m_valid);
      chk("cmd_out",   bus.cmd_out,   m_cmd);
      chk("arg_out",   bus.arg_out,   m_arg);
      chk("err_pulse", bus.err_pulse, m_err);
      chk("err_count", bus.err_count, m_cnt);
      chk("busy",      bus.busy,      fr.size() != 0);
   endtask

   task automatic cyc(input bit rv, input logic [7:0] d, input bit ak);
      bus.rx_valid = rv; bus.rx_data = d; bus.cmd_ack = ak;
      model(rv, d, ak);
      @(posedge clk); #1;
      check_all();
      bus.rx_valid = 0; bus.cmd_ack = 0;
   endtask

   task automatic frm(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input bit ak_last);
      cyc(1, SY, 0); cyc(1, c, 0); cyc(1, a, 0); cyc(1, k, ak_last);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'($urandom), 0);
   endtask

   bit rnd_ack;
   task automatic sendb(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) cyc(0, 8'($urandom), ($urandom_range(3) == 0));
      cyc(1, b, ($urandom_range(3) == 0));
   endtask

   initial begin
      bus.rx_valid = 0; bus.rx_data = 0; bus.cmd_ack = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_all();

      // Good frame then ack.
      frm(8'h01, 8'h3C, 8'h98, 0);
      cyc(0, 0, 1);
      idle_n(2);
      // Bad checksum.
      frm(8'h02, 8'h10, 8'h00, 0);
      idle_n(2);
      // Noise, then frame.
      cyc(1, 8'h00, 0); cyc(1, 8'hFF, 0);
      frm(8'h03, 8'h00, 8'hA6, 0);
      cyc(0, 0, 1);
      // Timeout after A5,01 then recovery.
      cyc(1, SY, 0); cyc(1, 8'h01, 0);
      idle_n(T + 3);
      frm(8'h01, 8'h3C, 8'h98, 0);
      // Overrun, then coincident ack loads the new frame.
      frm(8'h02, 8'h55, 8'h02 ^ 8'h55 ^ SY, 0);
      frm(8'h03, 8'h11, 8'h03 ^ 8'h11 ^ SY, 1);
      idle_n(2);
      // Reset in GET_ARG with a command pending.
      cyc(1, SY, 0); cyc(1, 8'h07, 0);
      #1 reset = 1'b1;
      #1;
      chk("rst_valid", bus.cmd_valid, 0);
      chk("rst_cmd",   bus.cmd_out,   0);
      chk("rst_err",   bus.err_count, 0);
      chk("rst_busy",  bus.busy,      0);
      m_reset();
      @(posedge clk); #1 reset = 1'b0;
      frm(8'h02, 8'h40, 8'h02 ^ 8'h40 ^ SY, 0);
      cyc(0, 0, 1);

      // Random traffic: good/bad frames, noise, stalled frames, random acks.
      for (int n = 0; n < 300; n++) begin
         logic [7:0] c, a;
         c = 8'($urandom); a = 8'($urandom);
         case ($urandom_range(5))
            0, 1, 2: begin
               sendb(SY, $urandom_range(3)); sendb(c, $urandom_range(3));
               sendb(a, $urandom_range(3));  sendb(c ^ a ^ SY, $urandom_range(3));
            end
            3: begin
               sendb(SY, $urandom_range(3)); sendb(c, $urandom_range(3));
               sendb(a, $urandom_range(3));  sendb(c ^ a ^ SY ^ 8'h01, $urandom_range(3));
            end
            4: sendb(8'($urandom), $urandom_range(2));
            default: begin
               sendb(SY, 1); sendb(c, 1);
               for (int i = 0; i < T + $urandom_range(4) - 2; i++) cyc(0, 0, ($urandom_range(3) == 0));
            end
         endcase
      end

      // Saturation.
      for (int n = 0; n < 260; n++) frm(8'h00, 8'h00, 8'h00, 0);
      idle_n(2);
      chk("err_sat", bus.err_count, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
